// File: rtl/jk_bank_driver_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// jk_bank_driver_if : target-request handshake and JK bank excitation bundle
// Revision 1.0
// ============================================================================
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_mode;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] step_cnt;

    // Requester / bank side.
    modport master (
        output tgt_valid, tgt_data, tgt_mode, q_fb,
        input  tgt_ready, j_out, k_out, busy, done, err, step_cnt
    );

    // Driver side.
    modport slave (
        input  tgt_valid, tgt_data, tgt_mode, q_fb,
        output tgt_ready, j_out, k_out, busy, done, err, step_cnt
    );
endinterface
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// jk_bank_driver : drives J/K of a flip-flop bank to a target word (direct load
//                  or stepwise count), verifies via Q feedback, retries on miss.
// Revision 1.0
// ============================================================================
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_bank_driver_if.slave  bus
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] C_RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COUNT  = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             up_q, up_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             match_q, match_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             w_accept;
    logic [WIDTH-1:0] w_step_base;
    logic             w_step_up;
    logic [WIDTH-1:0] w_step_nxt;
    logic [WIDTH-1:0] w_step_mask;
    logic [WIDTH-1:0] w_load_tgt;
    logic [WIDTH-1:0] w_load_j;
    logic [WIDTH-1:0] w_load_k;

    assign w_accept = bus.tgt_valid && ready_q;

    // The shadow cur_q always holds the value the bank reaches after the mask
    // currently on j/k, so the next step is computed from it directly.
    always_comb begin
        w_step_base = (state_q == S_IDLE) ? bus.q_fb : cur_q;
        w_step_up   = (state_q == S_IDLE) ? (bus.tgt_data > bus.q_fb) : up_q;
        w_step_nxt  = w_step_up ? (w_step_base + WIDTH'(1)) : (w_step_base - WIDTH'(1));
        w_step_mask = w_step_base ^ w_step_nxt;
        w_load_tgt  = (state_q == S_IDLE) ? bus.tgt_data : tgt_q;
        w_load_j    = w_load_tgt & ~bus.q_fb;
        w_load_k    = ~w_load_tgt & bus.q_fb;
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        up_d    = up_q;
        retry_d = retry_q;
        match_d = match_q;
        step_d  = step_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    tgt_d   = bus.tgt_data;
                    cur_d   = bus.q_fb;
                    up_d    = w_step_up;
                    retry_d = '0;
                    step_d  = '0;
                    if (!bus.tgt_mode) begin
                        state_d = S_LOAD;
                        j_d     = w_load_j;
                        k_d     = w_load_k;
                    end else if (bus.tgt_data != bus.q_fb) begin
                        state_d = S_COUNT;
                        j_d     = w_step_mask;
                        k_d     = w_step_mask;
                        cur_d   = w_step_nxt;
                        step_d  = WIDTH'(1);
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
            end
            S_COUNT: begin
                if (cur_q == tgt_q) begin
                    state_d = S_SETTLE;
                end else begin
                    j_d    = w_step_mask;
                    k_d    = w_step_mask;
                    cur_d  = w_step_nxt;
                    step_d = step_q + WIDTH'(1);
                end
            end
            S_SETTLE: begin
                // Verdict is registered here so done/err are flopped in CHECK.
                match_d = (bus.q_fb == tgt_q);
                done_d  = match_d;
                err_d   = !match_d && (retry_q == C_RETRY_MAX);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (match_q) begin
                    state_d = S_IDLE;
                end else if (retry_q < C_RETRY_MAX) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_LOAD;
                    j_d     = w_load_j;
                    k_d     = w_load_k;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            cur_q   <= '0;
            up_q    <= 1'b0;
            retry_q <= '0;
            match_q <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            up_q    <= up_d;
            retry_q <= retry_d;
            match_q <= match_d;
            j_q     <= j_d;
            k_q     <= k_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.tgt_ready = ready_q;
    assign bus.j_out     = j_q;
    assign bus.k_out     = k_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.step_cnt  = step_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_jk_bank_driver : closed-loop bench with a 4-bit JK bank on the driver.
// Revision 1.0
// ============================================================================
module tb_jk_bank_driver;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] bank_q;
    logic [W-1:0] fault_mask;

    always #5 clk = ~clk;

    jk_bank_driver_if #(.WIDTH(W)) bus ();

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // JK bank: Qn = J&~Q | ~K&Q, synchronous reset from ~rst_n.
    always @(posedge clk) begin
        if (!rst_n) bank_q <= '0;
        else        bank_q <= (bus.j_out & ~bank_q) | (~bus.k_out & bank_q);
    end
    assign bus.q_fb = bank_q & ~fault_mask;

    typedef struct {
        logic [3:0] data;
        logic       mode;
        logic [3:0] j0;
        logic [3:0] k0;
        logic [3:0] steps;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] steps;
        int         lat;
        bit         is_err;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[11];
    logic [3:0] mj[0:63];
    logic [3:0] mk[0:63];
    int         r_lat, r_done, r_err;
    logic       r_busy1, r_ready1;
    logic [3:0] model_bank;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_req(input logic [3:0] d, input logic m, input bit hold);
        int w;
        w = 0;
        r_lat = 0; r_done = 0; r_err = 0;
        while (!bus.tgt_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready before request", 32'(bus.tgt_ready), 32'd1);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = d;
        bus.tgt_mode  = m;
        @(posedge clk); #1;
        if (!hold) bus.tgt_valid = 1'b0;
        for (int c = 1; c < 64; c++) begin
            mj[c] = bus.j_out;
            mk[c] = bus.k_out;
            if (c == 1) begin
                r_busy1  = bus.busy;
                r_ready1 = bus.tgt_ready;
            end
            if (bus.done) r_done++;
            if (bus.err)  r_err++;
            if (bus.done || bus.err) begin
                r_lat = c;
                bus.tgt_valid = 1'b0;
                break;
            end
            if (hold) begin
                bus.tgt_data = 4'($urandom_range(0, 15));
                bus.tgt_mode = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_req(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(r_lat), 32'(e.lat));
        chk({tag, " done count"}, 32'(r_done), e.is_err ? 32'd0 : 32'd1);
        chk({tag, " err count"}, 32'(r_err), e.is_err ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        chk({tag, " ready/busy after"}, {30'd0, bus.tgt_ready, bus.busy}, 32'b10);
        chk({tag, " pulses cleared"}, {30'd0, bus.done, bus.err}, 32'd0);
        chk({tag, " step_cnt"}, 32'(bus.step_cnt), 32'(e.steps));
        chk({tag, " q_fb"}, 32'(bus.q_fb), 32'(e.tgt));
    endtask

    initial begin
        logic [3:0] cur, nxt;

        tbl[0]  = '{4'b1100, 1'b0, 4'b1100, 4'b0000, 4'd0,  3};
        tbl[1]  = '{4'b0110, 1'b0, 4'b0010, 4'b1000, 4'd0,  3};
        tbl[2]  = '{4'b0011, 1'b0, 4'b0001, 4'b0100, 4'd0,  3};
        tbl[3]  = '{4'b0110, 1'b1, 4'b0111, 4'b0111, 4'd3,  5};
        tbl[4]  = '{4'b0010, 1'b0, 4'b0000, 4'b0100, 4'd0,  3};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0011, 4'b0011, 4'd2,  4};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'd0,  2};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 4'd15, 17};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 4'd15, 17};
        tbl[9]  = '{4'b1010, 1'b0, 4'b1010, 4'b0000, 4'd0,  3};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 4'b1010, 4'd0,  3};

        bus.tgt_valid = 1'b0;
        bus.tgt_data  = '0;
        bus.tgt_mode  = 1'b0;
        fault_mask    = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset ready/busy", {30'd0, bus.tgt_ready, bus.busy}, 32'b10);
        chk("reset done/err", {30'd0, bus.done, bus.err}, 32'd0);
        chk("reset j/k", {24'd0, bus.j_out, bus.k_out}, 32'd0);
        chk("reset step_cnt", 32'(bus.step_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("bank after reset", 32'(bus.q_fb), 32'd0);
        model_bank = 4'b0000;

        for (int i = 0; i < 11; i++) begin
            sb.push_back('{tbl[i].data, tbl[i].steps, tbl[i].lat, 1'b0});
            run_req(tbl[i].data, tbl[i].mode, 1'b0);
            chk($sformatf("row%0d first j", i), 32'(mj[1]), 32'(tbl[i].j0));
            chk($sformatf("row%0d first k", i), 32'(mk[1]), 32'(tbl[i].k0));
            chk($sformatf("row%0d busy/ready", i), {30'd0, r_busy1, r_ready1}, 32'b10);
            if (tbl[i].mode) begin
                cur = model_bank;
                for (int s = 1; s <= int'(tbl[i].steps); s++) begin
                    nxt = (tbl[i].data > model_bank) ? cur + 4'd1 : cur - 4'd1;
                    chk($sformatf("row%0d mask step%0d", i, s),
                        {24'd0, mj[s], mk[s]}, {24'd0, cur ^ nxt, cur ^ nxt});
                    cur = nxt;
                end
            end
            finish_req($sformatf("row%0d", i));
            model_bank = tbl[i].data;
        end

        // Stuck-at-0 on q_fb[0]: three LOADs, then err.
        fault_mask = 4'b0001;
        sb.push_back('{4'b0000, 4'd0, 9, 1'b1});
        run_req(4'b0001, 1'b0, 1'b0);
        chk("fault load1 j/k", {24'd0, mj[1], mk[1]}, {24'd0, 4'b0001, 4'b0000});
        chk("fault settle j", 32'(mj[2]), 32'd0);
        chk("fault load2 j/k", {24'd0, mj[4], mk[4]}, {24'd0, 4'b0001, 4'b0000});
        chk("fault load3 j/k", {24'd0, mj[7], mk[7]}, {24'd0, 4'b0001, 4'b0000});
        finish_req("fault");
        fault_mask = 4'b0000;
        model_bank = 4'b0001;

        sb.push_back('{4'b0000, 4'd0, 3, 1'b0});
        run_req(4'b0000, 1'b0, 1'b0);
        chk("recover j/k", {24'd0, mj[1], mk[1]}, {24'd0, 4'b0000, 4'b0001});
        finish_req("recover");
        model_bank = 4'b0000;

        // Valid held high with churning data while busy.
        sb.push_back('{4'b0101, 4'd0, 3, 1'b0});
        run_req(4'b0101, 1'b0, 1'b1);
        finish_req("hold-valid");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold-valid idle", {27'd0, bus.busy, bus.q_fb}, {27'd0, 1'b0, 4'b0101});
        end

        // Asynchronous reset in the middle of a count-down from 0101.
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 4'b0000;
        bus.tgt_mode  = 1'b1;
        @(posedge clk); #1;
        bus.tgt_valid = 1'b0;
        chk("count1 mask", {24'd0, bus.j_out, bus.k_out}, {24'd0, 4'b0001, 4'b0001});
        @(posedge clk); #1;
        chk("count2 mask", {24'd0, bus.j_out, bus.k_out}, {24'd0, 4'b0111, 4'b0111});
        rst_n = 1'b0;
        #1;
        chk("midrst j/k", {24'd0, bus.j_out, bus.k_out}, 32'd0);
        chk("midrst ready/busy", {30'd0, bus.tgt_ready, bus.busy}, 32'b10);
        chk("midrst step_cnt", 32'(bus.step_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst bank", 32'(bus.q_fb), 32'd0);
        chk("post-rst ready/busy", {30'd0, bus.tgt_ready, bus.busy}, 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d/%0d)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
